// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select encodings
// and the shadow-slot record tracked for the EX, MEM and WB stages.
package pipe_hazard_ctrl_pkg;

    // Slot register fields are sized for the widest supported RA_W; narrower
    // addresses are zero-extended on entry, so RA_W must not exceed this.
    localparam int SLOT_RA_W = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int NSLOT    = 3;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RA_W-1:0] rs;
        logic [SLOT_RA_W-1:0] rt;
        logic                 use_rs;
        logic                 use_rt;
        logic [SLOT_RA_W-1:0] wr_reg;
        logic                 reg_write;
        logic                 mem_read;
    } slot_t;

endpackage

// File: rtl/pipe_hazard_ctrl_raw_cmp.sv
// Read-after-write detector: one source register against one in-flight slot.
// Register 0 is hardwired to zero and can never form a dependency.
module raw_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [SLOT_RA_W-1:0] src,
    input  logic                 src_used,
    input  slot_t                slot,
    output logic                 match
);

    logic unused_fields;

    assign match = slot.valid && slot.reg_write && (slot.wr_reg != '0)
                   && src_used && (slot.wr_reg == src);

    assign unused_fields = ^{slot.rs, slot.rt, slot.use_rs, slot.use_rt, slot.mem_read};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forwarding control for a 5-stage MIPS-style pipeline.
// Define PIPE_HAZARD_PERF_CNT_EN to add cycle, stall and flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32,
    parameter int FWD_MODE = 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RA_W-1:0] id_wr_reg,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            mem_br_taken,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            idex_bubble,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_exmem,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    slot_t slots [NSLOT];

    logic [SLOT_RA_W-1:0] id_src [2];
    logic [SLOT_RA_W-1:0] ex_src [2];
    logic [1:0]           id_use;
    logic [1:0]           ex_use;
    logic [1:0][NSLOT-1:0] id_m;
    logic [1:0][1:0]       ex_m;

    logic flush, stall_raw, stall;
    logic [1:0] fwd_a_c, fwd_b_c;

    always_comb begin
        slots[SLOT_EX]  = ex_q;
        slots[SLOT_MEM] = mem_q;
        slots[SLOT_WB]  = wb_q;
        id_src[0] = SLOT_RA_W'(id_rs);
        id_src[1] = SLOT_RA_W'(id_rt);
        id_use[0] = id_use_rs && id_valid;
        id_use[1] = id_use_rt && id_valid;
        ex_src[0] = ex_q.rs;
        ex_src[1] = ex_q.rt;
        ex_use[0] = ex_q.use_rs && ex_q.valid;
        ex_use[1] = ex_q.use_rt && ex_q.valid;
    end

    // ID sources are checked against every slot; EX sources only against MEM/WB.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            for (gj = 0; gj < NSLOT; gj++) begin : g_id
                raw_cmp u_id_cmp (
                    .src      (id_src[gi]),
                    .src_used (id_use[gi]),
                    .slot     (slots[gj]),
                    .match    (id_m[gi][gj])
                );
            end
            for (gj = 0; gj < 2; gj++) begin : g_ex
                raw_cmp u_ex_cmp (
                    .src      (ex_src[gi]),
                    .src_used (ex_use[gi]),
                    .slot     (slots[gj+1]),
                    .match    (ex_m[gi][gj])
                );
            end
        end
    endgenerate

    always_comb begin
        flush = mem_br_taken && !rst;
        if (FWD_MODE != 0) begin
            stall_raw = ex_q.mem_read && (id_m[0][SLOT_EX] || id_m[1][SLOT_EX]);
        end else begin
            stall_raw = |id_m;
        end
        // A taken branch wins so the target fetch is not held off.
        stall = stall_raw && !flush && !rst;

        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (FWD_MODE != 0 && !rst) begin
            fwd_a_c = ex_m[0][0] ? FWD_MEM : (ex_m[0][1] ? FWD_WB : FWD_RF);
            fwd_b_c = ex_m[1][0] ? FWD_MEM : (ex_m[1][1] ? FWD_WB : FWD_RF);
        end
    end

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign flush_ifid  = flush;
    assign flush_idex  = flush;
    assign flush_exmem = flush;
    assign fwd_a       = fwd_a_c;
    assign fwd_b       = fwd_b_c;

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = SLOT_RA_W'(id_rs);
            ex_d.rt        = SLOT_RA_W'(id_rt);
            ex_d.use_rs    = id_use_rs;
            ex_d.use_rt    = id_use_rt;
            ex_d.wr_reg    = SLOT_RA_W'(id_wr_reg);
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
        mem_d = flush ? '0 : ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        cyc_cnt_d   = cyc_cnt_q + CNT_W'(1);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one forwarding and one non-forwarding
// instance share stimulus; expected outputs flow through a scoreboard queue.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, mem_br_taken;
    logic [4:0] id_rs, id_rt, id_wr_reg;

    logic f_pc, f_ifid, f_bub, f_fi, f_fx, f_fm;
    logic n_pc, n_ifid, n_bub, n_fi, n_fx, n_fm;
    logic [1:0] f_fa, f_fb, n_fa, n_fb;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] f_cyc, f_stall, f_flush, n_cyc, n_stall, n_flush;
`endif

    logic [9:0] f_obs, n_obs;
    assign f_obs = {f_pc, f_ifid, f_bub, f_fi, f_fx, f_fm, f_fa, f_fb};
    assign n_obs = {n_pc, n_ifid, n_bub, n_fi, n_fx, n_fm, n_fa, n_fb};

    localparam logic [9:0] NONE  = 10'b000_000_00_00;
    localparam logic [9:0] STALL = 10'b111_000_00_00;
    localparam logic [9:0] FLUSH = 10'b000_111_00_00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [9:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_MODE(1)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_reg(id_wr_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_br_taken(mem_br_taken),
        .pc_stall(f_pc), .ifid_stall(f_ifid), .idex_bubble(f_bub),
        .flush_ifid(f_fi), .flush_idex(f_fx), .flush_exmem(f_fm),
        .fwd_a(f_fa), .fwd_b(f_fb)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .cyc_cnt(f_cyc), .stall_cnt(f_stall), .flush_cnt(f_flush)
`endif
    );

    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_MODE(0)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_reg(id_wr_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .mem_br_taken(mem_br_taken),
        .pc_stall(n_pc), .ifid_stall(n_ifid), .idex_bubble(n_bub),
        .flush_ifid(n_fi), .flush_idex(n_fx), .flush_exmem(n_fm),
        .fwd_a(n_fa), .fwd_b(n_fb)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .cyc_cnt(n_cyc), .stall_cnt(n_stall), .flush_cnt(n_flush)
`endif
    );

    task automatic id_set(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input int wr, input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_wr_reg    = 5'(wr);
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic id_idle();
        id_set(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One pipeline cycle: queue the expectation, compare mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step(input string tag, input bit sel, input logic [9:0] exp);
        exp_t e;
        exp_t got;
        logic [9:0] obs;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        obs = got.sel ? n_obs : f_obs;
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.exp);
        end
        $display("step %-12s dut=%s obs=%b exp=%b", got.tag, got.sel ? "nofwd" : "fwd", obs, got.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id_idle();
        for (int i = 0; i < 3; i++) step("drain", 1'b0, NONE);
    endtask

`ifdef PIPE_HAZARD_PERF_CNT_EN
    task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("cnt  %-12s obs=%0d exp=%0d", tag, obs, exp);
    endtask
    logic [31:0] s0, c0, fl0;
`endif

    initial begin
        rst = 1'b1;
        mem_br_taken = 1'b0;
        id_idle();
        @(posedge clk);
        #1;
        // Reset: a dependent instruction and a taken branch must not show.
        id_set(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        mem_br_taken = 1'b1;
        step("rst_fwd", 1'b0, NONE);
        step("rst_nofwd", 1'b1, NONE);
        rst = 1'b0;
        mem_br_taken = 1'b0;
        id_idle();
        step("idle", 1'b0, NONE);

        // Load-use: lw $2 ; add $3,$2,$4
        id_set(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        step("lu_lw", 1'b0, NONE);
        id_set(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        step("lu_stall", 1'b0, STALL);
        step("lu_release", 1'b0, NONE);
        id_idle();
        step("lu_fwd_wb", 1'b0, 10'b000_000_01_00);
        drain();

        // ALU-ALU: add $2 ; sub $5,$2,$2
        id_set(1'b1, 7, 8, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        step("alu_add", 1'b0, NONE);
        id_set(1'b1, 2, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
        step("alu_sub", 1'b0, NONE);
        id_idle();
        step("alu_fwd_mem", 1'b0, 10'b000_000_10_10);
        drain();

        // MEM priority: add $2 ; add $2 ; or $6,$2,$9
        id_set(1'b1, 7, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        step("pri_add1", 1'b0, NONE);
        id_set(1'b1, 8, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        step("pri_add2", 1'b0, NONE);
        id_set(1'b1, 2, 9, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        step("pri_or", 1'b0, NONE);
        id_idle();
        step("pri_fwd", 1'b0, 10'b000_000_10_00);
        drain();

        // No forwarding: add $2 ; add $3,$2 stalls through EX, MEM and WB.
        id_set(1'b1, 7, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        step("nf_add", 1'b1, NONE);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        s0 = n_stall;
        c0 = n_cyc;
`endif
        id_set(1'b1, 2, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
        step("nf_stall_ex", 1'b1, STALL);
        step("nf_stall_mem", 1'b1, STALL);
        step("nf_stall_wb", 1'b1, STALL);
        step("nf_release", 1'b1, NONE);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check_cnt("nf_stall_cnt", n_stall - s0, 32'd3);
        check_cnt("nf_cyc_cnt", n_cyc - c0, 32'd4);
`endif
        drain();

        // Branch taken while a load-use stall would assert.
        id_set(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        step("br_lw", 1'b0, NONE);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        fl0 = f_flush;
`endif
        id_set(1'b1, 2, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        mem_br_taken = 1'b1;
        step("br_flush", 1'b0, FLUSH);
        mem_br_taken = 1'b0;
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check_cnt("br_flush_cnt", f_flush - fl0, 32'd1);
`endif
        step("br_ex_inval", 1'b0, NONE);
        id_idle();
        step("br_mem_inval", 1'b0, NONE);
        drain();

        // Register 0: lw $0 ; add $3,$0,$0
        id_set(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        step("r0_lw", 1'b0, NONE);
        id_set(1'b1, 0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        step("r0_use", 1'b0, NONE);
        id_idle();
        step("r0_nofwd", 1'b0, NONE);
        drain();

        // Reset arriving in the middle of a stall.
        id_set(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        step("rs_lw", 1'b0, NONE);
        id_set(1'b1, 2, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
        step("rs_stall", 1'b0, STALL);
        rst = 1'b1;
        mem_br_taken = 1'b1;
        step("rs_in_rst", 1'b0, NONE);
        rst = 1'b0;
        mem_br_taken = 1'b0;
        step("rs_after", 1'b0, NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
